// File: rtl/debug_dump_serializer.sv
// ---------------------------------------------------------------------------
// debug_dump_serializer
//
// Takes a frozen copy of the pipeline debug buses when a dump is requested.
// It then streams that copy MSB-first, one byte at a time, into uart_tx using
// uart_tx's start/data/done handshake. Because the copy is frozen, the
// pipeline may keep running while the dump is in progress.
//
// Configuration macro: DEBUG_DUMP_FRAME_EN
//   undefined : the frame is exactly the N_BYTES raw snapshot bytes.
//   defined   : the frame is 0xA5, then the N_BYTES data bytes, then the XOR
//               checksum of the data bytes.
//
// Ports
//   clk          system clock (single domain)
//   i_rst_n      synchronous active-low reset
//   i_dump_req   start a dump (only honoured in IDLE)
//   i_id_ex      ID_EX debug bus   (NB_ID_EX bits)
//   i_ex_mem     EX_MEM debug bus  (NB_EX_MEM bits)
//   i_mem_wb     MEM_WB debug bus  (NB_MEM_WB bits)
//   i_wb_id      WB_ID debug bus   (NB_WB_ID bits)
//   i_control    CONTROL debug bus (NB_CONTROL bits)
//   i_tx_done    uart_tx done; a pulse or a level is accepted (rising edge used)
//   o_tx_start   one-cycle start pulse to uart_tx
//   o_tx_data    byte to uart_tx; held stable while waiting for done
//   o_busy       dump in progress
//   o_dump_done  one-cycle pulse once the last byte is acknowledged
//
// All outputs are registered from the current state. They therefore trail the
// FSM by one cycle: the start pulse appears two cycles after the request (or
// the acknowledging done edge) is sampled, and o_busy falls one cycle after
// o_dump_done.
// ---------------------------------------------------------------------------
module debug_dump_serializer #(
    parameter int NB_DATA    = 8,
    parameter int NB_ID_EX   = 144,
    parameter int NB_EX_MEM  = 32,
    parameter int NB_MEM_WB  = 40,
    parameter int NB_WB_ID   = 40,
    parameter int NB_CONTROL = 24
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_dump_req,
    input  logic [NB_ID_EX-1:0]   i_id_ex,
    input  logic [NB_EX_MEM-1:0]  i_ex_mem,
    input  logic [NB_MEM_WB-1:0]  i_mem_wb,
    input  logic [NB_WB_ID-1:0]   i_wb_id,
    input  logic [NB_CONTROL-1:0] i_control,
    input  logic                  i_tx_done,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic                  o_busy,
    output logic                  o_dump_done
);

    localparam int NB_SNAP = NB_ID_EX + NB_EX_MEM + NB_MEM_WB + NB_WB_ID + NB_CONTROL;
    localparam int N_BYTES = NB_SNAP / NB_DATA;
`ifdef DEBUG_DUMP_FRAME_EN
    localparam int FRAME_LEN = N_BYTES + 2;
`else
    localparam int FRAME_LEN = N_BYTES;
`endif
    localparam int NB_IDX      = $clog2(FRAME_LEN);
    localparam int LOG_NB_DATA = $clog2(NB_DATA);
    localparam int NB_SHAMT    = NB_IDX + LOG_NB_DATA;
    localparam logic [NB_IDX-1:0] LAST_IDX = NB_IDX'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [NB_IDX-1:0]    idx_q, idx_d;
    logic [NB_SNAP-1:0]   snap_q, snap_d;
    logic                 done_prev_q;
    logic                 tx_start_q, tx_start_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic                 busy_q, busy_d;
    logic                 dump_done_q, dump_done_d;

    logic                 done_rise_s;
    logic [NB_IDX-1:0]    data_idx_s;
    logic [NB_SHAMT-1:0]  shamt_s;
    logic [NB_SNAP-1:0]   shifted_s;
    logic [NB_DATA-1:0]   snap_byte_s;
    logic [NB_DATA-1:0]   tx_byte_s;

`ifdef DEBUG_DUMP_FRAME_EN
    logic [NB_DATA-1:0]   csum_q, csum_d;
`endif

    assign done_rise_s = i_tx_done & ~done_prev_q;

    // Data byte k sits at snap[NB_SNAP-1-8k -: 8]. Shift it up to the top
    // rather than using a variable part-select.
`ifdef DEBUG_DUMP_FRAME_EN
    // Frame index 0 is the header, so data byte = index - 1. At index 0 the
    // value wraps and is never used.
    assign data_idx_s = idx_q - NB_IDX'(1);
`else
    assign data_idx_s = idx_q;
`endif
    assign shamt_s     = NB_SHAMT'(data_idx_s) << LOG_NB_DATA;
    assign shifted_s   = snap_q << shamt_s;
    assign snap_byte_s = shifted_s[NB_SNAP-1 -: NB_DATA];

    // Select the frame byte that belongs to the current index.
    always_comb begin
`ifdef DEBUG_DUMP_FRAME_EN
        if (idx_q == {NB_IDX{1'b0}}) begin
            tx_byte_s = 8'hA5;
        end else if (idx_q == LAST_IDX) begin
            tx_byte_s = csum_q;
        end else begin
            tx_byte_s = snap_byte_s;
        end
`else
        tx_byte_s = snap_byte_s;
`endif
    end

    // State register: FSM state, byte index, snapshot, done edge detector, outputs.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {NB_IDX{1'b0}};
            snap_q      <= {NB_SNAP{1'b0}};
            done_prev_q <= 1'b0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= {NB_DATA{1'b0}};
            busy_q      <= 1'b0;
            dump_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            done_prev_q <= i_tx_done;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            busy_q      <= busy_d;
            dump_done_q <= dump_done_d;
        end
    end

    // Next-state logic: capture on request, then step through the frame on done edges.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (i_dump_req) begin
                    snap_d  = {i_id_ex, i_ex_mem, i_mem_wb, i_wb_id, i_control};
                    idx_d   = {NB_IDX{1'b0}};
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise_s) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + NB_IDX'(1);
                        state_d = ST_SEND;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the current state, registered in the state register block.
    always_comb begin
        tx_start_d  = 1'b0;
        tx_data_d   = {NB_DATA{1'b0}};
        busy_d      = 1'b0;
        dump_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_SEND: begin
                tx_start_d = 1'b1;
                tx_data_d  = tx_byte_s;
                busy_d     = 1'b1;
            end
            ST_WAIT: begin
                tx_data_d = tx_byte_s;
                busy_d    = 1'b1;
            end
            ST_DONE: begin
                busy_d      = 1'b1;
                dump_done_d = 1'b1;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

`ifdef DEBUG_DUMP_FRAME_EN
    // Checksum register: cleared at capture and folded once per data byte as it is sent.
    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            csum_q <= {NB_DATA{1'b0}};
        end else begin
            csum_q <= csum_d;
        end
    end

    // Checksum next value: header and checksum slots do not contribute.
    always_comb begin
        csum_d = csum_q;
        if ((state_q == ST_IDLE) && i_dump_req) begin
            csum_d = {NB_DATA{1'b0}};
        end else if ((state_q == ST_SEND) && (idx_q != {NB_IDX{1'b0}}) && (idx_q != LAST_IDX)) begin
            csum_d = csum_q ^ snap_byte_s;
        end else begin
            csum_d = csum_q;
        end
    end
`endif

    assign o_tx_start  = tx_start_q;
    assign o_tx_data   = tx_data_q;
    assign o_busy      = busy_q;
    assign o_dump_done = dump_done_q;

endmodule
